cla_seq_ctrl: RTL and testbench
===============================

CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 14: bit width of one carry-lookahead slice.
REQ-002 SHALL have parameter BEATS, default 4: number of slices per operation; legal range 2..16.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port i_valid, input, 1: an operand pair is offered.
REQ-006 SHALL have port o_ready, output, 1: the block can accept an operand pair.
REQ-007 SHALL have port i_add1, input, WIDTH*BEATS: operand A.
REQ-008 SHALL have port i_add2, input, WIDTH*BEATS: operand B.
REQ-009 SHALL have port o_valid, output, 1: o_result holds a completed sum.
REQ-010 SHALL have port i_ready, input, 1: the consumer accepts the result.
REQ-011 SHALL have port o_result, output, WIDTH*BEATS+1: {carry-out, sum}.
REQ-012 SHALL have port o_busy, output, 1: an operation is in progress (RUN or DONE).

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL assert o_ready only in IDLE.
REQ-015 SHALL, in IDLE, on i_valid&o_ready at a clock edge, latch both operands, clear the beat counter and the carry register, and enter RUN.
REQ-016 SHALL, in RUN, add one WIDTH-bit slice per cycle, LSB slice first (slice index = beat counter), with carry-in from the carry register.
REQ-017 SHALL, at each RUN edge, write the slice sum into o_result[cnt*WIDTH +: WIDTH], store the slice carry-out, and increment the counter.
REQ-018 SHALL, on the edge completing beat BEATS-1, write the final carry into o_result[WIDTH*BEATS] and enter DONE.
REQ-019 SHALL assert o_valid only in DONE, exactly BEATS cycles after the accept edge.
REQ-020 SHALL make o_result exact: (A+B) mod 2^(WIDTH*BEATS+1).
REQ-021 SHALL hold o_valid and o_result stable in DONE while i_ready is low (no timeout).
REQ-022 SHALL return to IDLE on o_valid&i_ready, so that o_ready is high in the following cycle.
REQ-023 SHALL ignore i_valid, i_add1 and i_add2 outside IDLE; operand changes during RUN shall not affect the result.
REQ-024 SHALL keep o_result unchanged in IDLE (last result retained); o_result is meaningful only while o_valid is high.
REQ-025 SHALL give a counter width of $clog2(BEATS); the counter shall never wrap past BEATS-1 while in RUN.

Reset
REQ-026 SHALL, on i_rst high at an edge, enter IDLE and clear the counter, the carry, the operand registers and o_result to 0.
REQ-027 SHALL give reset values: o_ready=1, o_valid=0, o_busy=0.
REQ-028 SHALL, on reset in RUN or DONE, abandon the operation with no o_valid pulse; reset takes priority over every handshake.

Configuration
REQ-029 SHALL add input i_sub (1 bit, latched at accept) when macro CLA_SEQ_SUB_EN is defined.
REQ-030 SHALL, when i_sub=1, compute A + ~B + 1 by inverting B slices and setting initial carry=1; o_result[WIDTH*BEATS] is then the no-borrow flag.
REQ-031 SHALL, without CLA_SEQ_SUB_EN, have no i_sub port and perform addition only; behaviour is otherwise identical.

Structure
REQ-032 SHALL define the FSM state enum and default WIDTH/BEATS constants in shared package cla_seq_pkg.
REQ-033 SHALL place the slice adder in sub-module cla_slice: a combinational WIDTH-bit carry-lookahead adder with carry-in/carry-out, using generate G=a&b and propagate P=a|b.

Verification
REQ-034 SHALL cover: A=0x3FFF, B=0x1 -> o_result=0x4000, checking that the slice-0 carry enters slice 1.
REQ-035 SHALL cover: A=0xFF_FFFF_FFFF_FFFF, B=0x1 -> o_result=0x100_0000_0000_0000, with o_valid exactly 4 cycles after accept.
REQ-036 SHALL cover: i_ready low for 5 cycles in DONE -> o_valid high, o_result stable, o_ready low throughout; o_ready=1 the cycle after the handshake.
REQ-037 SHALL cover: i_rst pulsed during RUN beat 2 -> next cycle o_busy=0, o_valid=0, o_ready=1, o_result=0; the next operation 0x1234+0x4321 gives 0x5555.
REQ-038 SHALL cover: with CLA_SEQ_SUB_EN, A=5, B=7, i_sub=1 -> o_result=0x0FF_FFFF_FFFF_FFFE (borrow, top bit 0); and A=7, B=5 -> 0x100_0000_0000_0002.
REQ-039 SHALL cover: 1000 random operand pairs with random i_valid/i_ready gaps -> every result equals the 57-bit reference sum, with no lost or duplicated transactions.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared FSM state type and default slice width / beat count for cla_seq_ctrl
package cla_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int WIDTH_DEF = 14;
  localparam int BEATS_DEF = 4;
endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational WIDTH-bit carry-lookahead adder (i_a, i_b, i_ci -> o_s, o_co) using g=a&b, p=a|b
module cla_slice #(
  parameter int WIDTH = 14
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co
);
  logic [WIDTH-1:0] gen, prop;
  logic [WIDTH:0]   c;
  assign gen  = i_a & i_b;
  assign prop = i_a | i_b;
  assign c[0] = i_ci;
  for (genvar i = 0; i < WIDTH; i++) begin : g_c
    assign c[i+1] = gen[i] | (prop[i] & c[i]);
  end
  assign o_s  = i_a ^ i_b ^ c[WIDTH-1:0];
  assign o_co = c[WIDTH];
endmodule

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: sequential multi-beat CLA adder; valid/ready operand in (i_add1,i_add2), valid/ready {carry,sum} out (o_result), o_busy; CLA_SEQ_SUB_EN adds i_sub (A+~B+1)
module cla_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BEATS = BEATS_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [WIDTH*BEATS-1:0] i_add1,
  input  logic [WIDTH*BEATS-1:0] i_add2,
`ifdef CLA_SEQ_SUB_EN
  input  logic                   i_sub,
`endif
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH*BEATS:0]   o_result,
  output logic                   o_busy
);
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, sub_q, sub_d, sub_in, co;
  logic [WIDTH*BEATS-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH*BEATS:0] res_q, res_d;
  logic [WIDTH-1:0] a_sl, b_sl, s;
`ifdef CLA_SEQ_SUB_EN
  assign sub_in = i_sub;
`else
  assign sub_in = 1'b0;
`endif
  assign a_sl = a_q[cnt_q*WIDTH +: WIDTH];
  assign b_sl = b_q[cnt_q*WIDTH +: WIDTH] ^ {WIDTH{sub_q}};
  cla_slice #(.WIDTH(WIDTH)) u_slice (.i_a(a_sl), .i_b(b_sl), .i_ci(carry_q), .o_s(s), .o_co(co));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (i_valid) begin
        a_d     = i_add1;
        b_d     = i_add2;
        sub_d   = sub_in;
        cnt_d   = '0;
        carry_d = sub_in;
        state_d = RUN;
      end
      RUN: begin
        res_d[cnt_q*WIDTH +: WIDTH] = s;
        carry_d = co;
        cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          res_d[WIDTH*BEATS] = co;
          state_d = DONE;
        end
      end
      DONE: state_d = i_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end
  assign o_ready  = state_q == IDLE;
  assign o_valid  = state_q == DONE;
  assign o_busy   = state_q != IDLE;
  assign o_result = res_q;
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb_cla_seq_ctrl: randomized self-checking bench for cla_seq_ctrl against an arithmetic reference
module tb_cla_seq_ctrl;
  localparam int WIDTH = 14;
  localparam int BEATS = 4;
  localparam int N = WIDTH * BEATS;
  logic i_clk = 1'b0;
  logic i_rst, i_valid, i_ready, i_sub;
  logic [N-1:0] i_add1, i_add2;
  logic o_ready, o_valid, o_busy;
  logic [N:0] o_result;
  int n_chk = 0;
  int n_fail = 0;
  always #5 i_clk = ~i_clk;
  cla_seq_ctrl #(.WIDTH(WIDTH), .BEATS(BEATS)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_add1(i_add1),
    .i_add2(i_add2),
`ifdef CLA_SEQ_SUB_EN
    .i_sub(i_sub),
`endif
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_result(o_result),
    .o_busy(o_busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [N:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    logic [N:0] two_n;
    two_n = '0;
    two_n[N] = 1'b1;
    return sub ? ({1'b0, a} + two_n - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  endfunction
  function automatic logic [N-1:0] rnd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return ($urandom_range(0, 5) == 0) ? '1 : r[N-1:0];
  endfunction
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub, input int hold, input string tag);
    logic [N:0] exp;
    int lat;
    exp = ref_sum(a, b, sub);
    lat = 0;
    while (!o_ready && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
    chk({tag, "_rdy"}, 64'(o_ready), 64'd1);
    i_valid = 1'b1;
    i_add1 = a;
    i_add2 = b;
    i_sub = sub;
    @(negedge i_clk);
    chk({tag, "_busy"}, 64'(o_busy), 64'd1);
    lat = 0;
    while (!o_valid && lat < 20) begin
      i_valid = 1'($urandom_range(0, 1));
      i_add1 = rnd();
      i_add2 = rnd();
      i_sub = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(BEATS));
    chk({tag, "_res"}, 64'(o_result), 64'(exp));
    repeat (hold) begin
      i_valid = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      chk({tag, "_hold_vld"}, 64'(o_valid), 64'd1);
      chk({tag, "_hold_res"}, 64'(o_result), 64'(exp));
      chk({tag, "_hold_rdy"}, 64'(o_ready), 64'd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    chk({tag, "_post_rdy"}, 64'(o_ready), 64'd1);
    chk({tag, "_post_vld"}, 64'(o_valid), 64'd0);
  endtask
  initial begin
    logic s;
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_sub = 1'b0;
    i_add1 = '0;
    i_add2 = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_result", 64'(o_result), 64'd0);
    i_rst = 1'b0;
    run_op(56'h3FFF, 56'h1, 1'b0, 0, "slice_carry");
    chk("slice_carry_const", 64'(o_result), 64'h4000);
    run_op(56'hFF_FFFF_FFFF_FFFF, 56'h1, 1'b0, 0, "full_wrap");
    chk("full_wrap_const", 64'(o_result), 64'h100_0000_0000_0000);
    run_op(rnd(), rnd(), 1'b0, 5, "hold5");
    i_valid = 1'b1;
    i_add1 = 56'hAAAA;
    i_add2 = 56'h5555;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_ready", 64'(o_ready), 64'd1);
    chk("mid_rst_result", 64'(o_result), 64'd0);
    repeat (6) begin
      @(negedge i_clk);
      chk("mid_rst_no_vld", 64'(o_valid), 64'd0);
    end
    run_op(56'h1234, 56'h4321, 1'b0, 0, "after_rst");
    chk("after_rst_const", 64'(o_result), 64'h5555);
`ifdef CLA_SEQ_SUB_EN
    run_op(56'd5, 56'd7, 1'b1, 1, "sub_borrow");
    chk("sub_borrow_const", 64'(o_result), 64'h0FF_FFFF_FFFF_FFFE);
    run_op(56'd7, 56'd5, 1'b1, 1, "sub_noborrow");
    chk("sub_noborrow_const", 64'(o_result), 64'h100_0000_0000_0002);
`endif
    for (int k = 0; k < 1000; k++) begin
      i_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
`ifdef CLA_SEQ_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      run_op(rnd(), rnd(), s, $urandom_range(0, 3), "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
